// File: rtl/xsim_top_pkg.sv
// Shared types and helpers for the xsim portal shell.
// Method ids, lengths, FSM states, header pack/unpack.
package xsim_top_pkg;

  localparam logic [15:0] METH_ECHO = 16'd0;
  localparam logic [15:0] METH_ADD  = 16'd1;
  localparam logic [15:0] LEN_ECHO  = 16'd2;
  localparam logic [15:0] LEN_ADD   = 16'd3;
  localparam logic [15:0] IND_LEN   = 16'd2;

  typedef enum logic [2:0] {
    IDLE,
    ARGS,
    DRAIN,
    SEND_HDR,
    SEND_DATA
  } state_t;

  function automatic logic [15:0] hdr_meth(
    input logic [31:0] h
  );
    return h[31:16];
  endfunction

  // A zero length is read as one word (the header alone).
  function automatic logic [15:0] hdr_len(
    input logic [31:0] h
  );
    return (h[15:0] == 16'd0) ? 16'd1 : h[15:0];
  endfunction

  function automatic logic [31:0] hdr_build(
    input logic [15:0] m,
    input logic [15:0] l
  );
    return {m, l};
  endfunction

endpackage

// File: rtl/xsim_msg_deframer.sv
// Request deframer: header decode, beat counter, argument capture.
// Ports: CLK/RST_N, state/acc/beat in; hdr flags, method, a, b, valid out.
import xsim_top_pkg::*;

module xsim_msg_deframer (
  input  logic        CLK,
  input  logic        RST_N,
  input  state_t      state,
  input  logic        acc,
  input  logic [31:0] beat,
  output logic        hdr_ok,
  output logic        hdr_short,
  output logic        last,
  output logic [15:0] method,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        valid
);

  logic [15:0] cnt;
  logic        idx;
  logic [15:0] meth;
  logic [15:0] len;

  assign meth = hdr_meth(beat);
  assign len  = hdr_len(beat);

  assign hdr_ok =
    ((meth == METH_ECHO) && (len == LEN_ECHO)) ||
    ((meth == METH_ADD)  && (len == LEN_ADD));

  assign hdr_short = (len == 16'd1);
  assign last      = (cnt == 16'd1);
  assign valid     = (state == ARGS) && acc && last;

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      cnt    <= 16'd0;
      idx    <= 1'b0;
      method <= 16'd0;
      a      <= 32'd0;
      b      <= 32'd0;
    end else if (acc) begin
      unique case (state)
        IDLE: begin
          cnt    <= len - 16'd1;
          method <= meth;
          idx    <= 1'b0;
        end
        ARGS: begin
          cnt <= cnt - 16'd1;
          idx <= 1'b1;
          if (!idx) a <= beat;
          else      b <= beat;
        end
        DRAIN: cnt <= cnt - 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mk_xsim_top.sv
// Portal shell: runs echo/add requests, emits 2-beat indications.
// Ports: CLK, RST_N (active-high), sink_* request in, src_* out, err_count.
import xsim_top_pkg::*;

module mk_xsim_top #(
  parameter logic [31:0] REQ_PORTAL = 32'd0,
  parameter logic [31:0] IND_PORTAL = 32'd1
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [31:0] sink_portal,
  input  logic        sink_src_rdy,
  input  logic [31:0] sink_beat,
  output logic        sink_deq,
  output logic [31:0] src_portal,
  output logic        src_en_beat,
  output logic [31:0] src_beat,
  output logic [15:0] err_count
);

  state_t      state;
  state_t      nxt;
  logic        acc;
  logic        err_inc;
  logic        hdr_ok;
  logic        hdr_short;
  logic        last;
  logic        valid;
  logic [15:0] method;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] payload;

  assign sink_portal = REQ_PORTAL;
  assign src_portal  = IND_PORTAL;

  assign sink_deq = !RST_N &&
    (state == IDLE || state == ARGS || state == DRAIN);
  assign acc = sink_src_rdy && sink_deq;

  assign payload = (method == METH_ADD) ? a + b : a;

  xsim_msg_deframer u_dfr (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .state     (state),
    .acc       (acc),
    .beat      (sink_beat),
    .hdr_ok    (hdr_ok),
    .hdr_short (hdr_short),
    .last      (last),
    .method    (method),
    .a         (a),
    .b         (b),
    .valid     (valid)
  );

  always_comb begin
    nxt     = state;
    err_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (hdr_ok) begin
            nxt = ARGS;
          end else begin
            err_inc = 1'b1;
            nxt     = hdr_short ? IDLE : DRAIN;
          end
        end
      end
      ARGS:      if (valid) nxt = SEND_HDR;
      DRAIN:     if (acc && last) nxt = IDLE;
      SEND_HDR:  nxt = SEND_DATA;
      SEND_DATA: nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      state       <= IDLE;
      src_en_beat <= 1'b0;
      src_beat    <= 32'd0;
      err_count   <= 16'd0;
    end else begin
      state <= nxt;
      if (err_inc && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
      // Output regs load one cycle ahead of the beat they show.
      if (valid) begin
        src_en_beat <= 1'b1;
        src_beat    <= hdr_build(method, IND_LEN);
      end else if (state == SEND_HDR) begin
        src_en_beat <= 1'b1;
        src_beat    <= payload;
      end else begin
        src_en_beat <= 1'b0;
        src_beat    <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mk_xsim_top.sv
// Directed bench for mk_xsim_top.
// Drives request beats, checks indications, err_count and sink_deq.
module tb_mk_xsim_top;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        sink_src_rdy = 1'b0;
  logic [31:0] sink_beat = 32'd0;
  logic [31:0] sink_portal;
  logic        sink_deq;
  logic [31:0] src_portal;
  logic        src_en_beat;
  logic [31:0] src_beat;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cnt = 0;
  logic [31:0] qb[$];
  int          qc[$];

  always #5 CLK = ~CLK;

  mk_xsim_top #(
    .REQ_PORTAL (32'd0),
    .IND_PORTAL (32'd1)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .sink_portal  (sink_portal),
    .sink_src_rdy (sink_src_rdy),
    .sink_beat    (sink_beat),
    .sink_deq     (sink_deq),
    .src_portal   (src_portal),
    .src_en_beat  (src_en_beat),
    .src_beat     (src_beat),
    .err_count    (err_count)
  );

  always @(negedge CLK) begin
    cyc++;
    if (src_en_beat) begin
      en_cnt++;
      qb.push_back(src_beat);
      qc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] bt);
    sink_src_rdy = 1'b1;
    sink_beat    = bt;
    tick();
    sink_src_rdy = 1'b0;
    sink_beat    = 32'd0;
  endtask

  task automatic clr();
    qb.delete();
    qc.delete();
    en_cnt = 0;
  endtask

  // Called right after the edge that accepted the last argument.
  task automatic resp(input string tag,
                      input logic [31:0] h,
                      input logic [31:0] d);
    chk({tag, "_deq0a"}, 32'(sink_deq), 32'd0);
    chk({tag, "_en_h"}, 32'(src_en_beat), 32'd1);
    chk({tag, "_hdr"}, src_beat, h);
    tick();
    chk({tag, "_deq0b"}, 32'(sink_deq), 32'd0);
    chk({tag, "_en_d"}, 32'(src_en_beat), 32'd1);
    chk({tag, "_data"}, src_beat, d);
    tick();
    chk({tag, "_en_off"}, 32'(src_en_beat), 32'd0);
    chk({tag, "_beat0"}, src_beat, 32'd0);
    chk({tag, "_deq1"}, 32'(sink_deq), 32'd1);
  endtask

  initial begin
    logic [31:0] feed [4];
    int          idx;
    logic        ok;

    repeat (2) tick();
    chk("rst_deq", 32'(sink_deq), 32'd0);
    chk("rst_en", 32'(src_en_beat), 32'd0);
    chk("rst_beat", src_beat, 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("req_portal", sink_portal, 32'd0);
    chk("ind_portal", src_portal, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("post_rst_deq", 32'(sink_deq), 32'd1);

    clr();
    put(32'h0000_0002);
    put(32'hDEAD_BEEF);
    resp("echo", 32'h0000_0002, 32'hDEAD_BEEF);
    chk("echo_en_cycles", 32'(en_cnt), 32'd2);

    clr();
    put(32'h0001_0003);
    put(32'hFFFF_FFFF);
    put(32'h0000_0002);
    resp("add", 32'h0001_0002, 32'h0000_0001);

    clr();
    put(32'h0007_0004);
    chk("unk_err", 32'(err_count), 32'd1);
    chk("unk_drain_deq", 32'(sink_deq), 32'd1);
    put(32'h1111_1111);
    put(32'h2222_2222);
    put(32'h3333_3333);
    repeat (3) tick();
    chk("unk_no_out", 32'(en_cnt), 32'd0);
    put(32'h0000_0002);
    put(32'h0000_0005);
    resp("echo5", 32'h0000_0002, 32'h0000_0005);

    clr();
    put(32'h0000_0003);
    chk("mis_err", 32'(err_count), 32'd2);
    put(32'hAAAA_0000);
    put(32'hBBBB_0000);
    repeat (3) tick();
    chk("mis_no_out", 32'(en_cnt), 32'd0);
    chk("mis_idle_deq", 32'(sink_deq), 32'd1);
    put(32'h0000_0000);
    chk("len0_err", 32'(err_count), 32'd3);
    chk("len0_deq", 32'(sink_deq), 32'd1);
    put(32'h0000_0002);
    put(32'h0000_0077);
    resp("len0_next", 32'h0000_0002, 32'h0000_0077);
    put(32'h0001_0001);
    chk("len1_err", 32'(err_count), 32'd4);

    clr();
    put(32'h0000_0002);
    repeat (10) tick();
    chk("stall_no_out", 32'(en_cnt), 32'd0);
    chk("stall_deq", 32'(sink_deq), 32'd1);
    RST_N = 1'b1;
    #1;
    chk("midrst_deq0", 32'(sink_deq), 32'd0);
    tick();
    RST_N = 1'b0;
    #1;
    chk("midrst_err", 32'(err_count), 32'd0);
    chk("midrst_deq1", 32'(sink_deq), 32'd1);
    // Late data beat is seen as a header: method 0, length 1.
    put(32'h0000_0001);
    repeat (3) tick();
    chk("late_no_out", 32'(en_cnt), 32'd0);
    chk("late_err", 32'(err_count), 32'd1);
    chk("late_deq", 32'(sink_deq), 32'd1);

    clr();
    feed[0] = 32'h0000_0002;
    feed[1] = 32'hA5A5_0001;
    feed[2] = 32'h0000_0002;
    feed[3] = 32'h5A5A_0002;
    idx = 0;
    for (int k = 0; k < 40 && idx < 4; k++) begin
      sink_src_rdy = 1'b1;
      sink_beat    = feed[idx];
      ok           = sink_deq;
      tick();
      if (ok) idx++;
    end
    sink_src_rdy = 1'b0;
    sink_beat    = 32'd0;
    repeat (4) tick();
    chk("b2b_fed", 32'(idx), 32'd4);
    chk("b2b_beats", 32'(qb.size()), 32'd4);
    if (qb.size() == 4) begin
      chk("b2b_h1", qb[0], 32'h0000_0002);
      chk("b2b_d1", qb[1], 32'hA5A5_0001);
      chk("b2b_h2", qb[2], 32'h0000_0002);
      chk("b2b_d2", qb[3], 32'h5A5A_0002);
      // Gap from first response's last beat to second's header.
      chk("b2b_gap", 32'(qc[2] - qc[1]), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mk_xsim_top.md
# mk_xsim_top

Simulation top-level portal shell. It consumes 32-bit request message beats from the host-side sink, decodes Connectal-style message headers, and executes two request methods: `echo` and `add`. It returns indication messages beat-by-beat on the host-side source. It sits between the simulator's message sink/source bridge and the application logic, as a single-clock block with no DMA.

## Interface
Parameters:
- `REQ_PORTAL`, default 0: portal number presented on `sink_portal`.
- `IND_PORTAL`, default 1: portal number presented on `src_portal`.

Ports:
- `CLK`, in, 1: the single clock. One clock; all logic on its rising edge.
- `RST_N`, in, 1: reset. Synchronous and active-high, despite the name; sampled on rising `CLK`.
- `sink_portal`, out, 32: constant `REQ_PORTAL`.
- `sink_src_rdy`, in, 1: a request beat is available.
- `sink_beat`, in, 32: request beat data.
- `sink_deq`, out, 1: block accepts a beat this cycle. Transfer happens when `sink_src_rdy && sink_deq`.
- `src_portal`, out, 32: constant `IND_PORTAL`.
- `src_en_beat`, out, 1: `src_beat` is valid this cycle. No backpressure; the consumer must take every beat.
- `src_beat`, out, 32: indication beat data.
- `err_count`, out, 16: count of rejected requests, saturating.

## Operation
Header beat format:
- Bits [31:16] are the method id.
- Bits [15:0] are the total message length in words, header included.
- A length of 0 is treated as 1.

Request methods:
- Method 0, `echo(v)`: required length 2. Responds with indication method 0, payload `v`.
- Method 1, `add(a,b)`: required length 3, `a` first. Responds with indication method 1, payload `(a+b) mod 2^32`.
- Any other method id, or a length mismatch for methods 0/1: the request is rejected.
  - All remaining length−1 beats are consumed and discarded.
  - No indication is sent.
  - `err_count` increments, saturating at 16'hFFFF.

Indication format: header beat `{method, 16'd2}`, then one payload beat.

State machine:
- `IDLE`: wait for a header beat.
  - On accept with length 1: go to `IDLE` and count an error, since both methods need arguments.
  - Otherwise go to `ARGS` if valid, `DRAIN` if rejected. Load the remaining-beat counter (16 bits) with length−1.
- `ARGS`: capture arguments in order; decrement the counter per accepted beat. When the last beat is accepted, go to `SEND_HDR`.
- `DRAIN`: discard beats; at counter 1 with a beat accepted, go to `IDLE`.
- `SEND_HDR`: drive the header on `src_beat` with `src_en_beat=1`, then go to `SEND_DATA`.
- `SEND_DATA`: drive the payload beat, then go to `IDLE`.

`sink_deq`:
- 1 in `IDLE`, `ARGS` and `DRAIN`.
- 0 in `SEND_HDR` and `SEND_DATA`, and in any cycle `RST_N` is 1.

## Timing
- Reset values:
  - state `IDLE`
  - `src_en_beat` 0
  - `src_beat` 32'h0
  - `err_count` 0
  - argument registers 0
  - `sink_deq` 0 while reset is asserted
- A reset asserted mid-message abandons the message and emits no partial indication. The cycle after reset deasserts, `sink_deq` is 1.
- Latency: last request beat accepted in cycle t → header out in t+1, payload in t+2 → `sink_deq`=1 again in t+3.
- `src_en_beat` is registered; `src_beat` holds 32'h0 when `src_en_beat`=0.
- Back-to-back requests: the next header can be accepted in t+3. No overlap of input and output phases.
- A gap in `sink_src_rdy` mid-message simply stalls the FSM; no timeout.
- The `err_count` increment happens in the cycle the header is accepted.

## Structure
- Shared package `xsim_top_pkg` holds:
  - the `METH_ECHO=16'd0` and `METH_ADD=16'd1` constants
  - expected lengths
  - the state enum
  - header field extract/build functions
- One natural sub-module: `xsim_msg_deframer`, containing the header decode, length counter and argument capture. It presents `{method, a, b, valid}` to the top, which owns the response FSM and `err_count`.

## Test plan
- Echo: `sink_beat` sequence 32'h0000_0002, 32'hDEAD_BEEF → `src_beat` 32'h0000_0002 then 32'hDEAD_BEEF, `src_en_beat` high for exactly 2 cycles.
- Add with wrap: 32'h0001_0003, 32'hFFFF_FFFF, 32'h0000_0002 → 32'h0001_0002, 32'h0000_0001.
- Unknown method with drain: 32'h0007_0004 plus 3 data beats → no `src_en_beat`, `err_count`=1. A following echo of 5 still returns 5.
- Length mismatch: 32'h0000_0003, then 2 beats → drained, `err_count` increments, no output. Length-0 header → `err_count` +1, next beat treated as a header.
- Stall and reset: echo header, then `sink_src_rdy` low for 10 cycles → no output; then assert `RST_N` for 1 cycle → state `IDLE`, `err_count`=0, and no indication appears when the data beat later arrives as a header.
- Latency: check `sink_deq`=0 for exactly 2 cycles after the last argument beat, and that back-to-back echoes produce responses 3 cycles apart.
